// File: rtl/systolic_array_8x8.sv
// -----------------------------------------------------------------------------
// systolic_array_8x8
//
// 8x8 weight-stationary systolic multiply-accumulate array. Each PE (r,c) holds
// an activation a[r][c], a weight b[r][c] and a partial sum ps[r][c].
//   - Weights enter at the top (row 0) and shift down one row per
//     en_b_shift_bottom pulse; the row-7 value is discarded.
//   - Activations enter at the left (column 0) and shift right one column per
//     en_shift_right pulse; the column-7 value is discarded.
//   - On en_shift_bottom each PE computes ps_above + a*b, so partial sums move
//     down one row per pulse and leave at the bottom of each column.
//   - data_clear zeroes every a and ps (priority over their shift enables);
//     weights are untouched and may still shift on the same edge.
// All operations on an edge read only pre-edge state.
//
// Ports:
//   Clock               single clock, rising edge
//   rst_n               asynchronous active-low reset (all state to 0)
//   data_clear          synchronous clear of a and ps registers
//   en_b_shift_bottom   shift weights down one row
//   en_shift_right      shift activations right one column
//   en_shift_bottom     MAC step, partial sums advance one row
//   a_left_in_flat[r]   activation entering row r
//   b_top_in_flat[c]    weight entering column c
//   ps_top_in_flat[c]   partial sum entering the top of column c
//   ps_bottom_out_flat[c] registered ps[7][c]
//
// Optional build macro SYSTOLIC_SAT_EN: the product is saturated to the signed
// DW-bit range and the PE add clamps to 0x7FFF / 0x8000 instead of wrapping.
// Without it the product is truncated to its low DW bits and the add wraps.
// -----------------------------------------------------------------------------
module systolic_array_8x8 #(
    parameter int DW = 16,
    parameter int N  = 8
) (
    input  logic          Clock,
    input  logic          rst_n,
    input  logic          data_clear,
    input  logic          en_b_shift_bottom,
    input  logic          en_shift_right,
    input  logic          en_shift_bottom,
    input  logic [DW-1:0] a_left_in_flat     [0:N-1],
    input  logic [DW-1:0] b_top_in_flat      [0:N-1],
    input  logic [DW-1:0] ps_top_in_flat     [0:N-1],
    output logic [DW-1:0] ps_bottom_out_flat [0:N-1]
);

    logic [DW-1:0] a_q    [0:N-1][0:N-1];
    logic [DW-1:0] b_q    [0:N-1][0:N-1];
    logic [DW-1:0] ps_q   [0:N-1][0:N-1];
    logic [DW-1:0] ps_nxt [0:N-1][0:N-1];

`ifdef SYSTOLIC_SAT_EN
    function automatic logic [DW-1:0] pe_mac(input logic [DW-1:0] ps_in,
                                             input logic [DW-1:0] a_in,
                                             input logic [DW-1:0] b_in);
        logic signed [2*DW-1:0] prod;
        logic        [DW-1:0]   prod_sat;
        logic        [DW:0]     sum;
        logic        [DW-1:0]   max_pos;
        logic        [DW-1:0]   max_neg;
        max_pos = {1'b0, {(DW-1){1'b1}}};
        max_neg = {1'b1, {(DW-1){1'b0}}};
        prod = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
        // The product fits in DW signed bits only when its top DW+1 bits agree.
        if (&prod[2*DW-1:DW-1] || ~|prod[2*DW-1:DW-1])
            prod_sat = prod[DW-1:0];
        else
            prod_sat = prod[2*DW-1] ? max_neg : max_pos;
        sum = {ps_in[DW-1], ps_in} + {prod_sat[DW-1], prod_sat};
        // A one-bit sign extension exposes overflow as disagreement of the top two bits.
        if (sum[DW] != sum[DW-1])
            return sum[DW] ? max_neg : max_pos;
        else
            return sum[DW-1:0];
    endfunction
`else
    // Low DW bits of a signed product equal those of the unsigned product,
    // so plain DW-bit arithmetic gives the truncating, wrapping result.
    function automatic logic [DW-1:0] pe_mac(input logic [DW-1:0] ps_in,
                                             input logic [DW-1:0] a_in,
                                             input logic [DW-1:0] b_in);
        return ps_in + a_in * b_in;
    endfunction
`endif

    always_comb begin
        for (int unsigned c = 0; c < N; c++) begin
            ps_nxt[0][c] = pe_mac(ps_top_in_flat[c], a_q[0][c], b_q[0][c]);
        end
        for (int unsigned r = 1; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                ps_nxt[r][c] = pe_mac(ps_q[r-1][c], a_q[r][c], b_q[r][c]);
            end
        end
    end

    // Weight registers: only the reset and en_b_shift_bottom touch them.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    b_q[r][c] <= '0;
        end else if (en_b_shift_bottom) begin
            for (int unsigned c = 0; c < N; c++)
                b_q[0][c] <= b_top_in_flat[c];
            for (int unsigned r = 1; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    b_q[r][c] <= b_q[r-1][c];
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    a_q[r][c] <= '0;
        end else if (data_clear) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    a_q[r][c] <= '0;
        end else if (en_shift_right) begin
            for (int unsigned r = 0; r < N; r++)
                a_q[r][0] <= a_left_in_flat[r];
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 1; c < N; c++)
                    a_q[r][c] <= a_q[r][c-1];
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    ps_q[r][c] <= '0;
        end else if (data_clear) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    ps_q[r][c] <= '0;
        end else if (en_shift_bottom) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    ps_q[r][c] <= ps_nxt[r][c];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N; c++)
            ps_bottom_out_flat[c] = ps_q[N-1][c];
    end

endmodule

// File: tb/tb_systolic_array_8x8.sv
module tb_systolic_array_8x8;

    logic        Clock = 1'b0;
    logic        rst_n;
    logic        data_clear;
    logic        en_b_shift_bottom;
    logic        en_shift_right;
    logic        en_shift_bottom;
    logic [15:0] a_in  [0:7];
    logic [15:0] b_in  [0:7];
    logic [15:0] ps_in [0:7];
    logic [15:0] ps_out[0:7];

    systolic_array_8x8 #(.DW(16), .N(8)) dut (
        .Clock              (Clock),
        .rst_n              (rst_n),
        .data_clear         (data_clear),
        .en_b_shift_bottom  (en_b_shift_bottom),
        .en_shift_right     (en_shift_right),
        .en_shift_bottom    (en_shift_bottom),
        .a_left_in_flat     (a_in),
        .b_top_in_flat      (b_in),
        .ps_top_in_flat     (ps_in),
        .ps_bottom_out_flat (ps_out)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference state: integer matrices updated from the rules once per edge.
    int ma [8][8];
    int mb [8][8];
    int mp [8][8];

    function automatic int sx16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Value of a PE as a signed 16-bit integer.
    function automatic int pe_ref(input int p, input int a, input int b);
        int prod;
        int sum;
        prod = a * b;
`ifdef SYSTOLIC_SAT_EN
        if (prod > 32767) prod = 32767;
        if (prod < -32768) prod = -32768;
        sum = p + prod;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
`else
        sum = (p + prod) & 32'hFFFF;
        if (sum > 32767) sum = sum - 65536;
`endif
        return sum;
    endfunction

    task automatic model_zero();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ma[r][c] = 0; mb[r][c] = 0; mp[r][c] = 0;
            end
    endtask

    task automatic model_edge(input bit bs, input bit sr, input bit sb, input bit clr);
        int na [8][8];
        int nb [8][8];
        int np [8][8];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (bs) nb[r][c] = (r == 0) ? sx16(b_in[c]) : mb[(r == 0) ? 0 : r-1][c];
                else    nb[r][c] = mb[r][c];
                if (clr)     na[r][c] = 0;
                else if (sr) na[r][c] = (c == 0) ? sx16(a_in[r]) : ma[r][(c == 0) ? 0 : c-1];
                else         na[r][c] = ma[r][c];
                if (clr)     np[r][c] = 0;
                else if (sb) np[r][c] = pe_ref((r == 0) ? sx16(ps_in[c]) : mp[(r == 0) ? 0 : r-1][c],
                                               ma[r][c], mb[r][c]);
                else         np[r][c] = mp[r][c];
            end
        ma = na; mb = nb; mp = np;
    endtask

    // Drive one edge: inputs already set by caller; controls applied here.
    task automatic cyc(input bit bs, input bit sr, input bit sb, input bit clr);
        en_b_shift_bottom = bs;
        en_shift_right    = sr;
        en_shift_bottom   = sb;
        data_clear        = clr;
        @(posedge Clock);
        model_edge(bs, sr, sb, clr);
        @(negedge Clock);
    endtask

    // Continuous check of every output against the reference.
    always @(negedge Clock) begin
        if (chk_on && rst_n) begin
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (ps_out[c] !== 16'(mp[7][c])) begin
                    errors++;
                    $display("FAIL model_cmp col%0d t=%0t: got %h expected %h",
                             c, $time, ps_out[c], 16'(mp[7][c]));
                end
            end
        end
    end

    // Hand-computed expectation: checks the DUT output and pins the model.
    task automatic lit(input string name, input int col, input logic [15:0] exp);
        checks++;
        if (ps_out[col] !== exp) begin
            errors++;
            $display("FAIL %s col%0d: got %h expected %h", name, col, ps_out[col], exp);
        end
        checks++;
        if (16'(mp[7][col]) !== exp) begin
            errors++;
            $display("FAIL %s_model col%0d: got %h expected %h", name, col, 16'(mp[7][col]), exp);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic reset_pulse(input string name);
        #2 rst_n = 1'b0;
        model_zero();
        #1;
        for (int c = 0; c < 8; c++) lit(name, c, 16'h0000);
        #1 rst_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic set_all(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] pv);
        for (int i = 0; i < 8; i++) begin
            a_in[i] = av; b_in[i] = bv; ps_in[i] = pv;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_all(16'h1234, 16'h5678, 16'h9ABC);
        en_b_shift_bottom = 1'b1; en_shift_right = 1'b1;
        en_shift_bottom = 1'b1;   data_clear = 1'b0;
        model_zero();
        #3;
        for (int c = 0; c < 8; c++) lit("reset_init", c, 16'h0000);
        @(negedge Clock);
        en_b_shift_bottom = 1'b0; en_shift_right = 1'b0; en_shift_bottom = 1'b0;
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (2) cyc(0, 0, 0, 0);
        for (int c = 0; c < 8; c++) lit("reset_hold", c, 16'h0000);

        // Weights of 1, zero activations: top partial sums pass straight through.
        set_all(16'h0000, 16'h0001, 16'h0000);
        for (int c = 0; c < 8; c++) ps_in[c] = 16'(c);
        repeat (8) cyc(1, 0, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
        for (int c = 0; c < 8; c++) lit("passthru", c, 16'(c));

        // Single MAC chain: b=2 everywhere, a=3 in column 0 only.
        cyc(0, 0, 0, 1);
        set_all(16'h0003, 16'h0002, 16'h0000);
        repeat (8) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
        lit("mac_chain", 0, 16'd48);
        for (int c = 1; c < 8; c++) lit("mac_chain", c, 16'h0000);

        // All three enables together must use pre-edge (zero) operands.
        reset_pulse("reset_mid");
        set_all(16'h0007, 16'h0005, 16'h0000);
        cyc(1, 1, 1, 0);
        repeat (7) cyc(0, 0, 1, 0);
        for (int c = 0; c < 8; c++) lit("simul_pre_edge", c, 16'h0000);
        cyc(0, 0, 1, 0);
        lit("simul_next", 0, 16'd35);
        for (int c = 1; c < 8; c++) lit("simul_next", c, 16'h0000);

        // Clear beats the MAC enable; weights survive it.
        cyc(0, 0, 1, 1);
        for (int c = 0; c < 8; c++) lit("clear", c, 16'h0000);
        set_all(16'h0001, 16'h0000, 16'h0000);
        cyc(0, 1, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
        lit("clear_b_kept", 0, 16'd5);
        for (int c = 1; c < 8; c++) lit("clear_b_kept", c, 16'h0000);

        // Overflow: single row of weights, then the full column.
        reset_pulse("reset_ovf");
        set_all(16'h7FFF, 16'h0002, 16'h0000);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
`ifdef SYSTOLIC_SAT_EN
        lit("ovf_row0", 0, 16'h7FFF);
`else
        lit("ovf_row0", 0, 16'hFFFE);
`endif
        repeat (7) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
`ifdef SYSTOLIC_SAT_EN
        lit("ovf_chain", 0, 16'h7FFF);
`else
        lit("ovf_chain", 0, 16'hFFF0);
`endif

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) begin
                a_in[k]  = 16'($urandom);
                b_in[k]  = 16'($urandom);
                ps_in[k] = 16'($urandom);
            end
            if (i == 200) reset_pulse("reset_rand");
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_8x8.md
Name: systolic_array_8x8

Overview:
- 8x8 weight-stationary systolic multiply-accumulate array of 64 processing elements (PEs), row r 0..7 and column c 0..7.
- Weights (B) load from the top and shift down. Activations (A) enter on the left and shift right. Partial sums enter from the top, accumulate down each column, and leave at the bottom.
- Sits under the FPGA register-file wrapper, which drives the operand buses and the enables and reads the bottom partial sums.

Parameters:
- DW, 16, data width of every operand, weight and partial sum.
- N, 8, array dimension. Fixed at 8; other values are not supported.

Ports:
- Clock  input  1  single clock, all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_clear  input  1  synchronous clear of A and partial-sum registers.
- en_b_shift_bottom  input  1  shift weight registers down one row.
- en_shift_right  input  1  shift activation registers right one column.
- en_shift_bottom  input  1  MAC step: partial sums advance down one row.
- a_left_in_flat  input  8x16 (unpacked array [0:7] of 16 bit)  A input for row r, element r.
- b_top_in_flat  input  8x16 (unpacked [0:7])  B input for column c, element c.
- ps_top_in_flat  input  8x16 (unpacked [0:7])  partial-sum input at top of column c.
- ps_bottom_out_flat  output  8x16 (unpacked [0:7])  partial sum leaving row 7 of column c.

Behaviour:
- Clocking and reset:
  - One clock (Clock); reset rst_n is asynchronous and active-low.
  - While rst_n=0, every a[r][c], b[r][c] and ps[r][c] is 0, so ps_bottom_out_flat[c]=0 for all c.
  - Reset asserted mid-operation zeroes all state immediately; it does not wait for a clock edge.
- Per-PE state: three 16-bit registers, a[r][c], b[r][c] and ps[r][c].
- B shift (en_b_shift_bottom=1):
  - b[0][c] <= b_top_in_flat[c].
  - b[r][c] <= b[r-1][c] for r=1..7.
  - The value held in row 7 is discarded.
  - 8 shifts load a full 8x8 weight matrix; the value loaded first ends up in row 7.
- A shift (en_shift_right=1):
  - a[r][0] <= a_left_in_flat[r].
  - a[r][c] <= a[r][c-1] for c=1..7.
  - The value held in column 7 is discarded.
- MAC step (en_shift_bottom=1):
  - ps[0][c] <= ps_top_in_flat[c] + a[0][c]*b[0][c].
  - ps[r][c] <= ps[r-1][c] + a[r][c]*b[r][c] for r=1..7.
  - The step uses pre-edge values of a, b and ps.
- Arithmetic:
  - Operands are two's-complement signed 16 bit.
  - The product is the low 16 bits of the 32-bit signed product.
  - The sum wraps modulo 2^16 (wrap behaviour is modified by the optional feature).
- Simultaneous enables:
  - All enabled operations occur on the same edge.
  - Each operation reads only pre-edge state; the MAC uses a and b values from before that edge's shifts.
- Disabled enables: each register group holds its value when its enable is 0.
- data_clear=1:
  - On the next edge all a and ps become 0.
  - This has priority over en_shift_right and en_shift_bottom.
  - b registers are unaffected, and en_b_shift_bottom still applies on that edge.
- Output path:
  - ps_bottom_out_flat[c] = ps[7][c], driven directly from the register with no combinational path from any input.
  - A value entering ps_top_in_flat appears at the output after 8 en_shift_bottom pulses.
- Accumulator lifetime: no implicit clearing between operations; use data_clear.

Optional Feature:
- Macro SYSTOLIC_SAT_EN.
- When defined: each PE add saturates to the signed 16-bit range, clamping to 16'h7FFF on positive overflow and 16'h8000 on negative overflow. The product is first saturated to the 16-bit signed range rather than truncated.
- When undefined: truncating product and wrapping add, as in Behaviour.

Test Plan:
- Reset: set all inputs nonzero, pulse rst_n low with no clock → all eight ps_bottom_out_flat are 0 immediately; after release with enables low they stay 0.
- Weight load, then MAC pass-through:
  - Stimulus: 8 en_b_shift_bottom pulses with b_top_in_flat[c]=1 for all c; a_left_in_flat[r]=0; ps_top_in_flat[c]=c.
  - Response: after 8 en_shift_bottom pulses, ps_bottom_out_flat[c]=c.
- Single MAC chain:
  - Stimulus: all b=2; one en_shift_right with a_left_in_flat[r]=3, so column 0 has a=3; ps_top_in_flat=0; 8 en_shift_bottom pulses.
  - Response: ps_bottom_out_flat[0]=8*6=48 and columns 1..7 are 0.
- Simultaneous enables:
  - Stimulus: with all a=0 and b=0, assert en_b_shift_bottom, en_shift_right and en_shift_bottom on one edge with inputs b=5, a=7, ps_top=0.
  - Response: ps[0][*] stays 0 because pre-edge operands are used; the next MAC edge gives ps[0][0]=35.
- data_clear:
  - Stimulus: with nonzero accumulated sums, assert data_clear together with en_shift_bottom.
  - Response: after the edge all ps and a are 0, and b is unchanged (verify by a new MAC giving the expected products).
- Overflow:
  - Stimulus: a=16'h7FFF, b=2, ps_top=0.
  - Response: without SYSTOLIC_SAT_EN the row-0 product is 16'hFFFE; with SYSTOLIC_SAT_EN it is 16'h7FFF, and the sum stays clamped through the chain.
